// File: rtl/ci_slice_scheduler_if.sv
// Start/done handshake and per-slice address pair between the slice scheduler
// and the filter custom-instruction master.
interface ci_slice_scheduler_if #(
    parameter int ADDRESSWIDTH = 32
);
    logic                    cm_start;
    logic [ADDRESSWIDTH-1:0] cm_dataa;
    logic [ADDRESSWIDTH-1:0] cm_datab;
    logic                    cm_done;

    modport master (
        output cm_start,
        output cm_dataa,
        output cm_datab,
        input  cm_done
    );

    modport slave (
        input  cm_start,
        input  cm_dataa,
        input  cm_datab,
        output cm_done
    );
endinterface

// File: rtl/ci_slice_scheduler.sv
// Walks the filter custom master across an image one slice at a time, with a
// per-slice watchdog and an abort that takes effect once the slice in flight ends.
module ci_slice_scheduler #(
    parameter int ADDRESSWIDTH   = 32,
    parameter int STRIDE_BYTES   = 480,
    parameter int COUNTWIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDRESSWIDTH-1:0] cfg_src_base,
    input  logic [ADDRESSWIDTH-1:0] cfg_dst_base,
    input  logic [COUNTWIDTH-1:0]   cfg_num_slices,
    input  logic                    cfg_go,
    input  logic                    cfg_abort,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [COUNTWIDTH-1:0]   slices_done,
    ci_slice_scheduler_if.master    cm
);

    localparam logic [ADDRESSWIDTH-1:0] STRIDE       = ADDRESSWIDTH'(STRIDE_BYTES);
    localparam logic [19:0]             TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 32'sd1);
    localparam logic [COUNTWIDTH-1:0]   CNT_ZERO     = {COUNTWIDTH{1'b0}};
    localparam logic [COUNTWIDTH-1:0]   CNT_ONE      = {{(COUNTWIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDRESSWIDTH-1:0] ADDR_ZERO    = {ADDRESSWIDTH{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_ADVANCE = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic                    go_accept_s;
    logic                    go_zero_s;
    logic                    timeout_s;
    logic [COUNTWIDTH-1:0]   slices_next_s;

    logic [ADDRESSWIDTH-1:0] src_r;
    logic [ADDRESSWIDTH-1:0] dst_r;
    logic [COUNTWIDTH-1:0]   num_r;
    logic [COUNTWIDTH-1:0]   slices_done_r;
    logic [19:0]             timer_r;
    logic                    abort_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    error_r;
    logic                    cm_start_r;

    assign busy        = busy_r;
    assign done        = done_r;
    assign error       = error_r;
    assign slices_done = slices_done_r;
    assign cm.cm_start = cm_start_r;
    assign cm.cm_dataa = src_r;
    assign cm.cm_datab = dst_r;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and per-cycle qualifiers for the datapath
    always_comb begin
        state_s       = state_r;
        go_accept_s   = 1'b0;
        go_zero_s     = 1'b0;
        timeout_s     = 1'b0;
        slices_next_s = slices_done_r + CNT_ONE;
        case (state_r)
            S_IDLE: begin
                if (cfg_go && (cfg_num_slices != CNT_ZERO)) begin
                    go_accept_s = 1'b1;
                    state_s     = S_ISSUE;
                end else if (cfg_go) begin
                    go_zero_s = 1'b1;
                    state_s   = S_IDLE;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_s = S_WAIT;
            end
            S_WAIT: begin
                if (cm.cm_done) begin
                    state_s = S_ADVANCE;
                end else if (timer_r == TIMEOUT_LAST) begin
                    timeout_s = 1'b1;
                    state_s   = S_FINISH;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_ADVANCE: begin
                // The abort flag only ends the job here, so the slice in flight always completes
                if ((slices_next_s == num_r) || abort_r) begin
                    state_s = S_FINISH;
                end else begin
                    state_s = S_ISSUE;
                end
            end
            S_FINISH: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Registered handshake and status outputs, derived from the upcoming state
    always_ff @(posedge clk) begin
        if (reset) begin
            cm_start_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            cm_start_r <= (state_s == S_ISSUE);
            busy_r     <= (state_s == S_ISSUE) || (state_s == S_WAIT) || (state_s == S_ADVANCE);
            done_r     <= (state_s == S_FINISH) || go_zero_s;
        end
    end

    // Job registers: latched configuration, slice addresses and progress
    always_ff @(posedge clk) begin
        if (reset) begin
            src_r         <= ADDR_ZERO;
            dst_r         <= ADDR_ZERO;
            num_r         <= CNT_ZERO;
            slices_done_r <= CNT_ZERO;
        end else if (go_accept_s) begin
            src_r         <= cfg_src_base;
            dst_r         <= cfg_dst_base;
            num_r         <= cfg_num_slices;
            slices_done_r <= CNT_ZERO;
        end else if (state_r == S_ADVANCE) begin
            src_r         <= src_r + STRIDE;
            dst_r         <= dst_r + STRIDE;
            slices_done_r <= slices_next_s;
        end
    end

    // Watchdog timer, abort flag and sticky timeout error
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_r <= 20'd0;
            abort_r <= 1'b0;
            error_r <= 1'b0;
        end else begin
            if (state_r == S_ISSUE) begin
                timer_r <= 20'd0;
            end else if ((state_r == S_WAIT) && !cm.cm_done) begin
                timer_r <= timer_r + 20'd1;
            end
            if (go_accept_s) begin
                abort_r <= 1'b0;
            end else if ((state_r == S_WAIT) && cfg_abort) begin
                abort_r <= 1'b1;
            end
            if (go_accept_s || go_zero_s) begin
                error_r <= 1'b0;
            end else if (timeout_s) begin
                error_r <= 1'b1;
            end
        end
    end

endmodule

// File: doc/ci_slice_scheduler.md
Name: ci_slice_scheduler

Overview:
Sequences the filter custom-instruction master across a whole image, one slice per invocation.
It takes a source base, a destination base and a slice count, then issues one start pulse per slice with per-slice addresses on dataa/datab. It waits for the master's done pulse before issuing the next slice, advancing both addresses by a fixed stride each time.
It sits between the control/CPU-side register interface and the custom master's start/dataa/datab/done ports. It adds a watchdog timeout and a graceful abort.

Parameters:
ADDRESSWIDTH, 32, width of base/slice addresses
STRIDE_BYTES, 480, byte increment of both addresses per slice (240 px x 2 bytes, one column)
COUNTWIDTH, 10, width of slice count/progress counters
TIMEOUT_CYCLES, 65535, maximum cycles to wait for cm_done before flagging error (20-bit compare)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
cfg_src_base  in  ADDRESSWIDTH  byte address of first unfiltered slice
cfg_dst_base  in  ADDRESSWIDTH  byte address of first filtered slice
cfg_num_slices  in  COUNTWIDTH  number of slices to process
cfg_go  in  1  start request, sampled in IDLE only
cfg_abort  in  1  stop after the slice in flight completes
busy  out  1  high from the cycle after an accepted cfg_go until the done pulse
done  out  1  one-cycle completion pulse (normal, abort, timeout or zero-count)
error  out  1  sticky timeout flag
slices_done  out  COUNTWIDTH  completed-slice count for the current job
cm_start  out  1  one-cycle start pulse to the custom master
cm_dataa  out  ADDRESSWIDTH  current source slice address
cm_datab  out  ADDRESSWIDTH  current destination slice address
cm_done  in  1  one-cycle done pulse from the custom master

Behaviour:
Reset values: all outputs 0; state IDLE; address registers 0; timer 0; abort flag 0.

States:
- IDLE:
  - cfg_go=1 and cfg_num_slices!=0: latch bases and count; clear slices_done, error and abort flag; go to ISSUE.
  - cfg_go=1 and cfg_num_slices==0: done=1 in the next cycle; stay IDLE; error cleared.
- ISSUE: cm_start=1 for exactly this cycle; clear timer; go to WAIT.
- WAIT:
  - cm_done=1: go to ADVANCE.
  - Otherwise timer++. When timer==TIMEOUT_CYCLES-1 without cm_done: go to FINISH with error set.
  - cfg_abort=1 sets the abort flag; the state does not change.
- ADVANCE: slices_done++; cm_dataa+=STRIDE_BYTES; cm_datab+=STRIDE_BYTES.
  - If the new slices_done==latched count, or the abort flag is set: go to FINISH.
  - Otherwise go to ISSUE.
- FINISH: done=1 for one cycle; go to IDLE.

Output and handshake rules:
- busy=1 in ISSUE, WAIT and ADVANCE; 0 in IDLE and FINISH.
- cm_dataa/cm_datab are registered. They are stable from ISSUE through WAIT and hold their last values in IDLE.
- Address arithmetic is unsigned modulo 2^ADDRESSWIDTH; wrap is silent.

Latency:
- cfg_go accepted in cycle n -> cm_start in n+1.
- cm_done in cycle t -> next cm_start in t+2.
- cm_done for the last slice in cycle t -> done in t+2.

Boundary conditions:
- cm_done outside WAIT, including the same cycle as cm_start: ignored.
- cfg_go while not in IDLE: ignored. cfg_base/count changes after latch: no effect.
- cfg_abort in IDLE, ISSUE or ADVANCE: ignored. The abort flag is sampled in WAIT only. An abort in the same cycle as cm_done counts.
- Timeout: slices_done is not incremented; error stays 1 until the next accepted cfg_go or reset.
- Reset mid-job: returns to IDLE in the next cycle with all outputs 0. No cm_start is issued.
- slices_done counts to the latched count with no wrap. A cfg_num_slices of the maximum value (1023) is legal.

Test Plan:
- Normal job: src=0x00001000, dst=0x00008000, num=3; the bench returns cm_done 10 cycles after each cm_start -> cm_start pulses with (dataa,datab) = (0x1000,0x8000), (0x11E0,0x81E0), (0x13C0,0x83C0); done 2 cycles after the third cm_done; slices_done=3; error=0.
- Zero count: cfg_go with num=0 -> no cm_start; done exactly 1 cycle later; busy stays 0.
- Timeout: TIMEOUT_CYCLES=16; cm_done never asserted -> done and error high 16 cycles after cm_start (+1 for FINISH); slices_done=0; next cfg_go clears error.
- Abort: num=5; cfg_abort pulsed during the WAIT of slice 2 -> done after slice 2's cm_done; slices_done=2; exactly 2 cm_start pulses.
- Interference: cfg_go and spurious cm_done pulsed during ISSUE and ADVANCE -> no extra slices; addresses unchanged; the job completes as in the normal case.
- Reset mid-WAIT, then address wrap: assert reset during slice 1 -> all outputs 0 next cycle. Then a new job with src=0xFFFFFF00, num=2 -> second dataa=0x000000E0.
